// File: rtl/mskaes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mskaes_pkg
// Purpose  : Shared constants, state encoding and GF(2^8) helpers for the
//            masked AES key schedule (round-constant source, MixColumns,
//            inverse key schedule).
// Revision : 1.0  initial release
// ============================================================================
package mskaes_pkg;

  // First constant of a forward pass (x^0) and of a backward pass (x^9).
  localparam logic [7:0] RCON_FWD_INIT = 8'h01;
  localparam logic [7:0] RCON_BWD_INIT = 8'h36;

  // Number of AES-128 rounds, i.e. constants per pass.
  localparam logic [3:0] AES_NROUNDS   = 4'd10;

  // AES reduction polynomial x^8 + x^4 + x^3 + x + 1, low byte only.
  localparam logic [7:0] AES_POLY_LO   = 8'h1b;

  // Low byte of x^-1 mod 0x11b folded back after a right rotation:
  // rotating bit 0 into bit 7 already supplies the x^7 term of 0x8d.
  localparam logic [7:0] AES_INV_FOLD  = 8'h0d;

  // Controller state encoding.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rcon_state_t;

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    logic [7:0] w_shl;
    w_shl = {a[6:0], 1'b0};
    return a[7] ? (w_shl ^ AES_POLY_LO) : w_shl;
  endfunction

  // Multiply by x^-1 in GF(2^8) modulo 0x11b (inverse of xtime).
  function automatic logic [7:0] inv_xtime(input logic [7:0] a);
    logic [7:0] w_rot;
    w_rot = {a[0], a[7:1]};
    return a[0] ? (w_rot ^ AES_INV_FOLD) : w_rot;
  endfunction

endpackage : mskaes_pkg
`default_nettype wire

// File: rtl/mskaes_rcon_bidir_cst.sv
`default_nettype none
// ============================================================================
// Module   : MSKcst
// Purpose  : Turns a public COUNT-bit constant into a D-share boolean sharing
//            (x, 0, ..., 0). No randomness is needed since the value is public.
// Revision : 1.0  initial release
// ============================================================================
module MSKcst #(
  parameter int unsigned D     = 2,
  parameter int unsigned COUNT = 8
) (
  input  logic [COUNT-1:0]   x,
  output logic [COUNT*D-1:0] y
);

  // Share 0 carries the value itself.
  assign y[COUNT-1:0] = x;

  // Remaining shares are tied to zero so the XOR of all shares equals x.
  generate
    if (D > 1) begin : g_zero_shares
      for (genvar i = 1; i < D; i++) begin : g_share
        assign y[i*COUNT +: COUNT] = '0;
      end
    end
  endgenerate

endmodule : MSKcst
`default_nettype wire

// File: rtl/mskaes_rcon_bidir.sv
`default_nettype none
// ============================================================================
// Module   : mskaes_rcon_bidir
// Purpose  : Bidirectional AES-128 round-constant generator with round
//            counter and start/update handshake. Forward pass walks
//            0x01 -> 0x36, backward pass walks 0x36 -> 0x01. The constant is
//            emitted as a non-random D-share sharing.
// Revision : 1.0  initial release
// ============================================================================
module mskaes_rcon_bidir
  import mskaes_pkg::*;
#(
  parameter int unsigned D = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           dir,
  input  logic           update,
  input  logic           rcon_en,
  output logic [8*D-1:0] sh_rcon,
  output logic [3:0]     round,
  output logic           last,
  output logic           busy
);

  rcon_state_t r_state;
  logic [7:0]  r_rcon;
  logic [3:0]  r_round;
  logic        r_dir;

  logic        w_busy;
  logic        w_last;
  logic        w_gate;
  logic [7:0]  w_rcon_gated;

  // Status derived purely from registered state.
  assign w_busy = (r_state == RUN);
  assign w_last = w_busy & (r_dir ? (r_round == 4'd1) : (r_round == AES_NROUNDS));

  // Single controller: rst beats start, start beats update; a start while
  // running restarts the pass and swallows a simultaneous update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rcon  <= RCON_FWD_INIT;
      r_round <= 4'd0;
      r_dir   <= 1'b0;
    end else if (start) begin
      r_state <= RUN;
      r_rcon  <= dir ? RCON_BWD_INIT : RCON_FWD_INIT;
      r_round <= dir ? AES_NROUNDS : 4'd1;
      r_dir   <= dir;
    end else if (update && (r_state == RUN)) begin
      if (w_last) begin
        // Pass complete; rcon is left as-is because the gate masks it.
        r_state <= IDLE;
        r_round <= 4'd0;
      end else if (r_dir) begin
        r_rcon  <= inv_xtime(r_rcon);
        r_round <= r_round - 4'd1;
      end else begin
        r_rcon  <= xtime(r_rcon);
        r_round <= r_round + 4'd1;
      end
    end
  end

  // Output gate is a pure AND so rcon_en takes effect in the same cycle.
  assign w_gate       = rcon_en & w_busy;
  assign w_rcon_gated = r_rcon & {8{w_gate}};

  MSKcst #(
    .D     (D),
    .COUNT (8)
  ) u_cst (
    .x (w_rcon_gated),
    .y (sh_rcon)
  );

  assign round = r_round;
  assign last  = w_last;
  assign busy  = w_busy;

endmodule : mskaes_rcon_bidir
`default_nettype wire

// File: tb/tb_mskaes_rcon_bidir.sv
`default_nettype none
// ============================================================================
// Module   : tb_mskaes_rcon_bidir
// Purpose  : Self-checking bench for mskaes_rcon_bidir with D = 3.
// Revision : 1.0  initial release
// ============================================================================
module tb_mskaes_rcon_bidir;

  localparam int unsigned D = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           dir = 1'b0;
  logic           update = 1'b0;
  logic           rcon_en = 1'b1;
  logic [8*D-1:0] sh_rcon;
  logic [3:0]     round;
  logic           last;
  logic           busy;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: pass state is just busy/direction/round; the constant
  // for round r is x^(r-1) in GF(2^8), independent of direction.
  bit       m_busy = 0;
  bit       m_dir  = 0;
  int       m_round = 0;
  bit [7:0] tbl [0:10];

  // Literal constant sequence of a forward pass.
  bit [7:0] fwd_seq [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  mskaes_rcon_bidir #(.D(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dir     (dir),
    .update  (update),
    .rcon_en (rcon_en),
    .sh_rcon (sh_rcon),
    .round   (round),
    .last    (last),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic void build_table();
    int v;
    tbl[0] = 8'h00;
    v = 1;
    for (int r = 1; r <= 10; r++) begin
      tbl[r] = v[7:0];
      v = v * 2;
      if (v >= 256) v = v ^ 'h11b;
    end
  endfunction

  function automatic bit [7:0] xor_shares(input logic [8*D-1:0] s);
    bit [7:0] acc = 8'h00;
    for (int i = 0; i < D; i++) acc ^= s[i*8 +: 8];
    return acc;
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle.
  task automatic cyc(input bit r, input bit s, input bit dr, input bit u, input bit e);
    rst = r; start = s; dir = dr; update = u; rcon_en = e;
    @(posedge clk);
    if (r) begin
      m_busy = 0; m_dir = 0; m_round = 0;
    end else if (s) begin
      m_busy = 1; m_dir = dr; m_round = dr ? 10 : 1;
    end else if (u && m_busy) begin
      if (m_round == (m_dir ? 1 : 10)) begin
        m_busy = 0; m_round = 0;
      end else begin
        m_round = m_dir ? m_round - 1 : m_round + 1;
      end
    end
    #1;
    rst = 0; start = 0; update = 0;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 1);
    n_total++;
    if (busy !== 1'b0 || last !== 1'b0 || round !== 4'd0 || sh_rcon !== '0)
      $display("FAIL reset: busy=%b last=%b round=%0d sh=%h, want 0 0 0 0", busy, last, round, sh_rcon);
    else n_pass++;
  endtask

  task automatic test_forward();
    cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc(0, 0, 0, 1, 1);
      n_total++;
      if (sh_rcon !== {16'h0, fwd_seq[i]} || round !== 4'(i + 1) || last !== (i == 9) || busy !== 1'b1)
        $display("FAIL fwd[%0d]: sh=%h round=%0d last=%b busy=%b, want %h %0d %b 1",
                 i, sh_rcon, round, last, busy, {16'h0, fwd_seq[i]}, i + 1, (i == 9));
      else n_pass++;
    end
    cyc(0, 0, 0, 1, 1);
    n_total++;
    if (busy !== 1'b0 || sh_rcon !== '0 || round !== 4'd0 || last !== 1'b0)
      $display("FAIL fwd_end: busy=%b sh=%h round=%0d last=%b, want 0 0 0 0", busy, sh_rcon, round, last);
    else n_pass++;
  endtask

  task automatic test_backward();
    cyc(0, 1, 1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc(0, 0, 0, 1, 1);
      n_total++;
      if (sh_rcon !== {16'h0, fwd_seq[9 - i]} || round !== 4'(10 - i) || last !== (i == 9) || busy !== 1'b1)
        $display("FAIL bwd[%0d]: sh=%h round=%0d last=%b busy=%b, want %h %0d %b 1",
                 i, sh_rcon, round, last, busy, {16'h0, fwd_seq[9 - i]}, 10 - i, (i == 9));
      else n_pass++;
    end
    cyc(0, 0, 0, 1, 1);
    n_total++;
    if (busy !== 1'b0 || sh_rcon !== '0 || round !== 4'd0)
      $display("FAIL bwd_end: busy=%b sh=%h round=%0d, want 0 0 0", busy, sh_rcon, round);
    else n_pass++;
  endtask

  task automatic test_gating();
    cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc(0, 0, 0, 1, 1);
      if (fwd_seq[i] == 8'h04 || fwd_seq[i] == 8'h80) begin
        rcon_en = 0;
        #1;
        n_total++;
        if (sh_rcon !== '0 || round !== 4'(i + 1))
          $display("FAIL gate_off[%0d]: sh=%h round=%0d, want 0 %0d", i, sh_rcon, round, i + 1);
        else n_pass++;
        rcon_en = 1;
        #1;
        n_total++;
        if (sh_rcon !== {16'h0, fwd_seq[i]})
          $display("FAIL gate_on[%0d]: sh=%h, want %h", i, sh_rcon, {16'h0, fwd_seq[i]});
        else n_pass++;
      end
    end
    cyc(0, 0, 0, 1, 1);
  endtask

  task automatic test_reset_restart();
    // Reset mid-pass on constant 0x10.
    cyc(0, 1, 0, 0, 1);
    for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 1, 1);
    n_total++;
    if (sh_rcon[7:0] !== 8'h10) $display("FAIL pre_rst: sh0=%h, want 10", sh_rcon[7:0]);
    else n_pass++;
    cyc(1, 0, 0, 1, 1);
    n_total++;
    if (busy !== 1'b0 || round !== 4'd0 || sh_rcon !== '0)
      $display("FAIL mid_rst: busy=%b round=%0d sh=%h, want 0 0 0", busy, round, sh_rcon);
    else n_pass++;
    // Restart backward with a colliding update on constant 0x08.
    cyc(0, 1, 0, 0, 1);
    for (int i = 1; i <= 3; i++) cyc(0, 0, 0, 1, 1);
    cyc(0, 1, 1, 1, 1);
    n_total++;
    if (sh_rcon !== {16'h0, 8'h36} || round !== 4'd10 || busy !== 1'b1)
      $display("FAIL restart: sh=%h round=%0d busy=%b, want 36 10 1", sh_rcon, round, busy);
    else n_pass++;
    // rst and start together: reset wins.
    cyc(1, 1, 1, 0, 1);
    n_total++;
    if (busy !== 1'b0 || round !== 4'd0)
      $display("FAIL rst_start: busy=%b round=%0d, want 0 0", busy, round);
    else n_pass++;
    // update in IDLE does nothing; a following start still begins at 0x01.
    cyc(0, 0, 0, 1, 1);
    n_total++;
    if (busy !== 1'b0 || round !== 4'd0 || sh_rcon !== '0)
      $display("FAIL idle_upd: busy=%b round=%0d sh=%h, want 0 0 0", busy, round, sh_rcon);
    else n_pass++;
    cyc(0, 1, 0, 0, 1);
    n_total++;
    if (sh_rcon !== {16'h0, 8'h01} || round !== 4'd1)
      $display("FAIL idle_then_start: sh=%h round=%0d, want 01 1", sh_rcon, round);
    else n_pass++;
    cyc(1, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit [7:0] exp_c;
    bit       exp_l;
    for (int n = 0; n < 500; n++) begin
      cyc(($urandom_range(99) < 3), ($urandom_range(99) < 8), $urandom_range(1),
          ($urandom_range(99) < 65), ($urandom_range(99) < 80));
      exp_c = (m_busy && rcon_en) ? tbl[m_round] : 8'h00;
      exp_l = m_busy && (m_round == (m_dir ? 1 : 10));
      n_total++;
      if (sh_rcon !== {16'h0, exp_c} || xor_shares(sh_rcon) !== exp_c ||
          round !== 4'(m_round) || last !== exp_l || busy !== m_busy)
        $display("FAIL rand[%0d]: sh=%h round=%0d last=%b busy=%b, want %h %0d %b %b",
                 n, sh_rcon, round, last, busy, {16'h0, exp_c}, m_round, exp_l, m_busy);
      else n_pass++;
    end
  endtask

  initial begin
    build_table();
    test_reset();
    test_forward();
    test_backward();
    test_gating();
    test_reset_restart();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mskaes_rcon_bidir
`default_nettype wire
